// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 hold decoder: code width, FSM encoding
// and the binary-to-one-hot helper.
package decoder_pkg;

    localparam int SEL_W = 3;
    localparam int N_OUT = 1 << SEL_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] code);
        return N_OUT'(1) << code;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decode; the top registers the result.
module onehot_dec
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0] code,
    output logic [N_OUT-1:0] lines
);

    assign lines = onehot(code);

endmodule

// File: rtl/decoder_3to8_hold.sv
// Registered 3-to-8 decoder that holds each decoded line for HOLD_CYCLES clocks
// and chains back-to-back codes without a gap cycle.
module decoder_3to8_hold
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_OUT-1:0] out_onehot,
    output logic             out_valid,
    output logic             done
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("decoder_3to8_hold: HOLD_CYCLES must be in 1..255");
    end
    if ((64'd1 << CNT_W) <= 64'(HOLD_CYCLES)) begin : g_bad_cnt_w
        $error("decoder_3to8_hold: CNT_W too narrow for HOLD_CYCLES");
    end

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N_OUT-1:0] onehot_q;
    logic             done_q;
    logic [N_OUT-1:0] dec;
    logic             last_cycle;
    logic             accept;

    onehot_dec u_dec (
        .code  (in_code),
        .lines (dec)
    );

    // Handshake: a code transfers on a rising edge where in_valid and in_ready
    // are both 1; the source holds in_code steady until then. in_ready is 1 in
    // IDLE and on the final hold cycle, so a follow-on code continues seamlessly.
    assign last_cycle = (state == ST_ACTIVE) && (cnt == CNT_ONE);
    assign in_ready   = (state == ST_IDLE) || last_cycle;
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            onehot_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    state    <= ST_ACTIVE;
                    cnt      <= HOLD_LOAD;
                    onehot_q <= dec;
                end
            end else begin
                if (accept) begin
                    cnt      <= HOLD_LOAD;
                    onehot_q <= dec;
                end else if (last_cycle) begin
                    // Hold expired with nothing queued behind it.
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    onehot_q <= '0;
                    done_q   <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
            end
        end
    end

    assign out_onehot = onehot_q;
    assign out_valid  = (state == ST_ACTIVE);
    assign done       = done_q;

endmodule

// File: tb/tb_decoder_3to8_hold.sv
// Bench for decoder_3to8_hold: a HOLD_CYCLES=4 instance driven by a vector
// table plus directed sequences, and a HOLD_CYCLES=1 instance for streaming.
module tb_decoder_3to8_hold;

    localparam int H4 = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n4, rst_n1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [2:0] in_code4, in_code1;
    logic       in_valid4, in_valid1;
    logic       in_ready4, in_ready1;
    logic [7:0] out_onehot4, out_onehot1;
    logic       out_valid4, out_valid1;
    logic       done4, done1;

    decoder_3to8_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n4),
        .in_code    (in_code4),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .out_onehot (out_onehot4),
        .out_valid  (out_valid4),
        .done       (done4)
    );

    decoder_3to8_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n1),
        .in_code    (in_code1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .out_onehot (out_onehot1),
        .out_valid  (out_valid1),
        .done       (done1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / reference model for dut4 ----------------
    logic [2:0] exp_q[$];
    logic [7:0] m_line = 8'h00;
    int         m_left = 0;
    logic       m_done = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n4) begin
                m_line = 8'h00;
                m_left = 0;
                m_done = 1'b0;
            end else begin
                chk("mon_onehot", {24'h0, out_onehot4}, {24'h0, m_line});
                chk("mon_valid", {31'h0, out_valid4}, {31'h0, (m_left != 0)});
                chk("mon_ready", {31'h0, in_ready4}, {31'h0, (m_left <= 1)});
                chk("mon_done", {31'h0, done4}, {31'h0, m_done});
                chk("mon_onehot0", {31'h0, $onehot0(out_onehot4)}, 32'h1);
                if (in_valid4 && (m_left <= 1)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_order: got code %0d want none", in_code4);
                    end else begin
                        chk("sb_order", {29'h0, in_code4}, {29'h0, exp_q.pop_front()});
                    end
                    m_line = 8'h01 << in_code4;
                    m_left = H4;
                    m_done = 1'b0;
                end else if (m_left == 1) begin
                    m_line = 8'h00;
                    m_left = 0;
                    m_done = 1'b1;
                end else begin
                    if (m_left > 1) m_left = m_left - 1;
                    m_done = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [2:0] c);
        bit got;
        int k;
        got = 1'b0;
        k = 0;
        exp_q.push_back(c);
        in_code4  = c;
        in_valid4 = 1'b1;
        while (!got && k < 20) begin
            @(negedge clk);
            got = in_ready4;
            step();
            k++;
        end
        in_valid4 = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: got no accept want accept of code %0d", c);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [2:0] code;
        logic [7:0] oh;
        logic       ov;
        logic       rdy;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [2:0] code, input logic [7:0] oh,
                                input logic ov, input logic rdy, input logic dn);
        vec_t r;
        r.v = v; r.code = code; r.oh = oh; r.ov = ov; r.rdy = rdy; r.dn = dn;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] order[10];
        logic [7:0] e;

        rst_n4 = 1'b0; rst_n1 = 1'b0;
        in_valid4 = 1'b0; in_code4 = 3'd0;
        in_valid1 = 1'b0; in_code1 = 3'd0;

        // Single code 5, then idle
        tbl.push_back(mk(1, 5, 8'h00, 0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 8'h20, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h20, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0));
        // Back-to-back 0 then 7 on the final hold cycle
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 8'h01, 1, 0, 0));
        tbl.push_back(mk(1, 7, 8'h01, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 8'h80, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h80, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0));
        // Backpressure: code 2 held valid through the hold of code 6
        tbl.push_back(mk(1, 6, 8'h00, 0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 2, 8'h40, 1, 0, 0));
        tbl.push_back(mk(1, 2, 8'h40, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 8'h04, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h04, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_onehot4", {24'h0, out_onehot4}, 32'h0);
        chk("rst_valid4", {31'h0, out_valid4}, 32'h0);
        chk("rst_ready4", {31'h0, in_ready4}, 32'h1);
        chk("rst_done4", {31'h0, done4}, 32'h0);
        chk("rst_onehot1", {24'h0, out_onehot1}, 32'h0);
        chk("rst_ready1", {31'h0, in_ready1}, 32'h1);
        rst_n4 = 1'b1; rst_n1 = 1'b1;
        step();

        // Table-driven vectors
        exp_q.push_back(3'd5); exp_q.push_back(3'd0); exp_q.push_back(3'd7);
        exp_q.push_back(3'd6); exp_q.push_back(3'd2);
        for (int i = 0; i < tbl.size(); i++) begin
            in_valid4 = tbl[i].v;
            in_code4  = tbl[i].code;
            @(negedge clk);
            chk($sformatf("tbl%0d_onehot", i), {24'h0, out_onehot4}, {24'h0, tbl[i].oh});
            chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid4}, {31'h0, tbl[i].ov});
            chk($sformatf("tbl%0d_ready", i), {31'h0, in_ready4}, {31'h0, tbl[i].rdy});
            chk($sformatf("tbl%0d_done", i), {31'h0, done4}, {31'h0, tbl[i].dn});
            step();
        end
        in_valid4 = 1'b0;
        chk("tbl_drained", exp_q.size(), 32'h0);

        // Reset mid-hold with line 5 (8'h20) driven
        send4(3'd5);
        step();
        chk("pre_rst_onehot", {24'h0, out_onehot4}, 32'h20);
        #2;
        rst_n4 = 1'b0;
        #1;
        chk("midrst_onehot", {24'h0, out_onehot4}, 32'h0);
        chk("midrst_valid", {31'h0, out_valid4}, 32'h0);
        chk("midrst_done", {31'h0, done4}, 32'h0);
        chk("midrst_ready", {31'h0, in_ready4}, 32'h1);
        step();
        rst_n4 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("postrst_no_done", {31'h0, done4}, 32'h0);
            step();
        end

        // HOLD_CYCLES=1 streaming 0..7
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1'b1;
            in_code1  = 3'(i);
            @(negedge clk);
            e = (i == 0) ? 8'h00 : (8'h01 << (i - 1));
            chk($sformatf("h1_walk%0d", i), {24'h0, out_onehot1}, {24'h0, e});
            chk($sformatf("h1_ready%0d", i), {31'h0, in_ready1}, 32'h1);
            chk($sformatf("h1_done%0d", i), {31'h0, done1}, 32'h0);
            step();
        end
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("h1_last_onehot", {24'h0, out_onehot1}, 32'h80);
        chk("h1_last_valid", {31'h0, out_valid1}, 32'h1);
        chk("h1_last_done", {31'h0, done1}, 32'h0);
        step();
        @(negedge clk);
        chk("h1_end_onehot", {24'h0, out_onehot1}, 32'h0);
        chk("h1_end_valid", {31'h0, out_valid1}, 32'h0);
        chk("h1_end_done", {31'h0, done1}, 32'h1);
        step();
        @(negedge clk);
        chk("h1_done_once", {31'h0, done1}, 32'h0);
        step();

        // All codes with random idle gaps, plus a repeated code back-to-back
        order = '{3'd3, 3'd1, 3'd6, 3'd0, 3'd7, 3'd2, 3'd5, 3'd4, 3'd4, 3'd1};
        for (int i = 0; i < 10; i++) begin
            if (i < 8) repeat ($urandom_range(0, 3)) step();
            send4(order[i]);
        end
        repeat (H4 + 3) step();
        chk("exh_drained", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
